// File: rtl/count_sched_pkg.sv
// count_sched_pkg
//   Shared types and default constants for the count_sched block.
//   - state_e     : scheduler FSM state encoding (IDLE, RUN, DONE)
//   - NUM_REQ_DEF : default number of requesters sharing the counter
//   - CNT_W_DEF   : default counter / interval-length width
package count_sched_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/count_sched_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin selector. The search starts at
//   last_winner_i+1 and wraps cyclically, so the previous winner has the
//   lowest priority.
// Ports:
//   req_i         in  NUM_REQ          request vector
//   last_winner_i in  $clog2(NUM_REQ)  index granted most recently
//   winner_o      out $clog2(NUM_REQ)  selected index (0 when no request)
//   any_req_o     out 1                at least one request bit is high
module rr_arbiter
    import count_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_winner_i,
    output logic [$clog2(NUM_REQ)-1:0] winner_o,
    output logic                       any_req_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        // off = NUM_REQ wraps back to last_winner itself, lowest priority.
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = ID_W'((int'(last_winner_i) + off) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found    = 1'b1;
                winner_o = idx;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/count_sched.sv
// count_sched
//   Shared interval counter time-multiplexed between NUM_REQ requesters.
//   An IDLE cycle with requests grants one requester round-robin, captures
//   its interval length, and runs the counter for max(len,1) cycles, then
//   emits a one-cycle done pulse tagged with the requester index.
//
//   state | meaning
//   IDLE  | waiting for a request; count holds its last value
//   RUN   | counting the granted interval, one cycle per count value
//   DONE  | one-cycle completion, done high
//
// Ports:
//   clk      in  1                rising-edge clock
//   rst      in  1                synchronous active-high reset
//   req      in  NUM_REQ          per-requester interval request (level)
//   len      in  NUM_REQ*CNT_W    per-requester interval length
//   ack      out NUM_REQ          one-hot grant pulse, first RUN cycle
//   busy     out 1                state is not IDLE
//   count    out CNT_W            shared counter value
//   done     out 1                completion pulse
//   done_id  out $clog2(NUM_REQ)  index of completed requester
//   abort    in  1                (COUNT_SCHED_ABORT_EN only) end RUN early
//   aborted  out 1                (COUNT_SCHED_ABORT_EN only) done was an abort
//
// Build option: define COUNT_SCHED_ABORT_EN to add the abort/aborted ports.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CNT_W-1:0]   len,
`ifdef COUNT_SCHED_ABORT_EN
    input  logic                       abort,
    output logic                       aborted,
`endif
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy,
    output logic [CNT_W-1:0]           count,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    last_winner_q, last_winner_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               done_q, done_d;
`ifdef COUNT_SCHED_ABORT_EN
    logic               aborted_q, aborted_d;
`endif

    logic [ID_W-1:0]    winner;
    logic               any_req;
    logic [CNT_W-1:0]   sel_len;
    // One extra bit so limit = 2^CNT_W-1 is reached without wrapping.
    logic [CNT_W:0]     count_inc;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i         (req),
        .last_winner_i (last_winner_q),
        .winner_o      (winner),
        .any_req_o     (any_req)
    );

    always_comb begin
        sel_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) sel_len = len[i*CNT_W +: CNT_W];
        end
    end

    assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_winner_d = last_winner_q;
        done_id_d     = done_id_q;
        limit_d       = limit_q;
        count_d       = count_q;
        ack_d         = '0;
        done_d        = 1'b0;
`ifdef COUNT_SCHED_ABORT_EN
        aborted_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d       = RUN;
                    owner_d       = winner;
                    last_winner_d = winner;
                    limit_d       = sel_len;
                    count_d       = '0;
                    ack_d         = NUM_REQ'(1) << winner;
                end
            end
            RUN: begin
`ifdef COUNT_SCHED_ABORT_EN
                if (abort) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                    aborted_d = 1'b1;
                end else
`endif
                if ((count_inc == {1'b0, limit_q}) || (limit_q == '0)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                end else begin
                    count_d = count_inc[CNT_W-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            last_winner_q <= ID_W'(NUM_REQ - 1);
            done_id_q     <= '0;
            limit_q       <= '0;
            count_q       <= '0;
            ack_q         <= '0;
            done_q        <= 1'b0;
`ifdef COUNT_SCHED_ABORT_EN
            aborted_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_winner_q <= last_winner_d;
            done_id_q     <= done_id_d;
            limit_q       <= limit_d;
            count_q       <= count_d;
            ack_q         <= ack_d;
            done_q        <= done_d;
`ifdef COUNT_SCHED_ABORT_EN
            aborted_q     <= aborted_d;
`endif
        end
    end

    assign ack     = ack_q;
    assign busy    = (state_q != IDLE);
    assign count   = count_q;
    assign done    = done_q;
    assign done_id = done_id_q;
`ifdef COUNT_SCHED_ABORT_EN
    assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_count_sched.sv
// tb_count_sched
//   Directed stimulus for count_sched. Each scenario pushes the acks and
//   dones it expects into a scoreboard queue; a monitor pops and compares
//   whenever the DUT shows ack or done. Works with or without
//   COUNT_SCHED_ABORT_EN.
module tb_count_sched;

    localparam int N = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N*W-1:0] len;
    logic [N-1:0] ack;
    logic         busy;
    logic [W-1:0] count;
    logic         done;
    logic [1:0]   done_id;
`ifdef COUNT_SCHED_ABORT_EN
    logic         abort;
    logic         aborted;
`endif

    count_sched #(.NUM_REQ(N), .CNT_W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len     (len),
`ifdef COUNT_SCHED_ABORT_EN
        .abort   (abort),
        .aborted (aborted),
`endif
        .ack     (ack),
        .busy    (busy),
        .count   (count),
        .done    (done),
        .done_id (done_id)
    );

    always #5 clk = ~clk;

    // gap: for an ack, cycles since the previous ack (0 = not checked);
    //      for a done, cycles since its ack (= number of RUN cycles).
    typedef struct {
        bit is_done;
        int id;
        int gap;
        bit ab;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_ack_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input bit d, input int id, input int gap, input bit ab);
        exp_t e;
        e.is_done = d;
        e.id      = id;
        e.gap     = gap;
        e.ab      = ab;
        sb.push_back(e);
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (ack !== '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack=%b expected none (cycle %0d)", ack, cyc);
            end else begin
                e = sb.pop_front();
                chk("order_ack", 32'(e.is_done), 32'd0);
                chk("ack_onehot", 32'(ack), 32'(1) << e.id);
                if (e.gap > 0) chk("ack_spacing", cyc - last_ack_cyc, e.gap);
            end
            last_ack_cyc = cyc;
        end
        if (done !== 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=%b id=%0d expected none (cycle %0d)", done, done_id, cyc);
            end else begin
                e = sb.pop_front();
                chk("order_done", 32'(e.is_done), 32'd1);
                chk("done_id", 32'(done_id), e.id);
                chk("run_cycles", cyc - last_ack_cyc, e.gap);
`ifdef COUNT_SCHED_ABORT_EN
                chk("aborted", 32'(aborted), 32'(e.ab));
`endif
            end
        end
    end

    task automatic set_len(input int i, input int v);
        len[i*W +: W] = W'(v);
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack === '0 && n < 20);
        if (ack === '0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no ack expected ack within 20 cycles", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 50);
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s: got busy=%b expected idle within 50 cycles", name, busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        rst = 1'b1;
        req = '0;
        len = '0;
`ifdef COUNT_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single requester, len 3
        set_len(0, 3);
        req = 4'b0001;
        push(0, 0, 0, 0);
        push(1, 0, 3, 0);
        wait_ack("t1_ack");
        req = '0;
        chk("t1_count0", 32'(count), 32'd0);
        chk("t1_busy_run", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_ack_one_cycle", 32'(ack), 32'd0);
        chk("t1_count1", 32'(count), 32'd1);
        @(negedge clk);
        chk("t1_count2", 32'(count), 32'd2);
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_done", 32'(busy), 32'd1);
        chk("t1_count_hold_done", 32'(count), 32'd2);
        @(negedge clk);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_count_hold_idle", 32'(count), 32'd2);

        // Fresh reset, all four requesting with len 1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_len(i, 1);
        req = 4'b1111;
        push(0, 0, 0, 0);
        push(1, 0, 1, 0);
        for (int i = 1; i < N; i++) begin
            push(0, i, 3, 0);
            push(1, i, 1, 0);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            req = req & ~ack;
        end
        wait_idle("t2_idle");
        chk("t2_all_served", 32'(req), 32'd0);

        // len 0 on requester 2
        set_len(2, 0);
        req = 4'b0100;
        push(0, 2, 0, 0);
        push(1, 2, 1, 0);
        wait_ack("t3a_ack");
        req = '0;
        chk("t3a_count0", 32'(count), 32'd0);
        @(negedge clk);
        chk("t3a_done", 32'(done), 32'd1);
        wait_idle("t3a_idle");

        // len 15 on requester 2: count 0..14, no wrap
        set_len(2, 15);
        req = 4'b0100;
        push(0, 2, 0, 0);
        push(1, 2, 15, 0);
        wait_ack("t3b_ack");
        req = '0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            if (count !== W'(i) || busy !== 1'b1) bad++;
        end
        chk("t3b_count_seq_errs", 32'(bad), 32'd0);
        @(negedge clk);
        chk("t3b_done", 32'(done), 32'd1);
        chk("t3b_count_final", 32'(count), 32'd14);
        wait_idle("t3b_idle");

        // Reset in 2nd RUN cycle of len 5
        set_len(1, 5);
        req = 4'b0010;
        push(0, 1, 0, 0);
        wait_ack("t4_ack");
        req = '0;
        chk("t4_count0", 32'(count), 32'd0);
        @(negedge clk);
        chk("t4_count1", 32'(count), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_count", 32'(count), 32'd0);
        chk("t4_rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) set_len(i, 1);
        req = 4'b1111;
        push(0, 0, 0, 0);
        push(1, 0, 1, 0);
        wait_ack("t4_regrant");
        req = '0;
        wait_idle("t4_idle");

        // len changed after the grant has no effect
        set_len(3, 3);
        req = 4'b1000;
        push(0, 3, 0, 0);
        push(1, 3, 3, 0);
        wait_ack("t5_ack");
        req = '0;
        set_len(3, 9);
        wait_idle("t5_idle");
        chk("t5_count_final", 32'(count), 32'd2);

        // len 10, abort in 3rd RUN cycle when the option is built in
        set_len(0, 10);
        req = 4'b0001;
        push(0, 0, 0, 0);
`ifdef COUNT_SCHED_ABORT_EN
        push(1, 0, 3, 1);
        wait_ack("t6_ack");
        req = '0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_abort_done", 32'(done), 32'd1);
        chk("t6_aborted", 32'(aborted), 32'd1);
        wait_idle("t6_idle");
        chk("t6_count_final", 32'(count), 32'd2);
`else
        push(1, 0, 10, 0);
        wait_ack("t6_ack");
        req = '0;
        wait_idle("t6_idle");
        chk("t6_count_final", 32'(count), 32'd9);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
